mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the 8:1 select multiplexer.
- Up to 8 requesters compete for the shared mux; the arbiter grants exactly one at a time.
- It drives the mux select lines s2,s1,s0 with the granted index so x carries y[owner].
- It holds each grant until the owner releases it, with an optional forced timeout.

Parameters:
HOLD_MAX, 16, maximum GRANT-state cycles per ownership when the timeout feature is compiled in (legal range 2..255).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
req  input  8  request vector; req[i] high = requester i wants the mux
done  input  1  owner release strobe, sampled only in GRANT
gnt  output  8  one-hot grant, registered; all-zero when no owner
s2  output  1  mux select bit 2 (owner index [2])
s1  output  1  mux select bit 1 (owner index [1])
s0  output  1  mux select bit 0 (owner index [0])
busy  output  1  high while in GRANT
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n=0, independent of clk.
- Reset values:
  - state=IDLE, gnt=8'h00, {s2,s1,s0}=3'b000, busy=0, timeout=0.
  - Internal pointer ptr=0; hold counter cnt=0.
- Owner index: internal 3-bit register; {s2,s1,s0} = owner at all times. In IDLE the register holds its last value (0 after reset); only gnt marks validity.
- IDLE state:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: owner=pick, gnt=1<<pick, busy=1, cnt=0, state=GRANT.
  - Latency from req sampled to gnt visible: 1 cycle.
- GRANT state:
  - Release when done=1 or req[owner]=0 (sampled at the edge).
  - On release: gnt=0, busy=0, ptr=owner+1 mod 8 (wraps 7->0), state=IDLE.
  - There is a mandatory one-cycle dead cycle in IDLE between owners. No back-to-back grants, even to a different requester.
  - While not releasing: gnt, owner and select stay stable; cnt increments by 1, saturating at 255.
- Simultaneous events:
  - Requests from non-owners during GRANT are ignored until IDLE.
  - done and req[owner] deassert together: a single ordinary release.
  - done while in IDLE: ignored.
- Fairness: a continuously requesting set of K requesters each receives a grant within K grant periods.
- gnt is always one-hot or zero. The gnt index always equals {s2,s1,s0} while busy=1.
- Reset mid-grant: gnt drops to 0 asynchronously; ptr returns to 0.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when cnt==HOLD_MAX-1 and no normal release occurs this edge, force a release: same actions as a normal release, plus timeout=1 for exactly the next cycle.
  - A normal release on that same edge takes precedence, and timeout stays 0.
  - An owner therefore holds the mux for at most HOLD_MAX cycles.
- Not defined:
  - No forced release; cnt may be omitted.
  - The timeout port still exists and is tied to 0.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle -> gnt=00, {s2,s1,s0}=000, busy=0 immediately, with no clk edge required.
2. Single requester: req=8'h20 at edge N -> edge N+1 gnt=20, sel=101, busy=1. Then done=1 for one cycle -> next edge gnt=00, busy=0, ptr=6.
3. Round-robin wrap: req=8'hFF held, each owner pulses done after 2 cycles -> grant order 0,1,...,7,0. Each grant is separated by exactly one cycle of gnt=00.
4. Pointer skip: after owner 6 releases (ptr=7), req=8'h05 -> gnt=01 (index 0 is reached via wrap), then after release gnt=04.
5. Request drop and ignored done: owner 3 deasserts req[3] with done=0 -> release on that edge. Separately, done=1 while in IDLE with req=0 -> no state change.
6. With ARB_TIMEOUT_EN, HOLD_MAX=4: req=8'h01 held, done=0 -> gnt=01 for exactly 4 cycles, then gnt=00 with timeout=1 for 1 cycle, then re-grant to 0 after the dead cycle. Without the macro, gnt=01 stays high for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bus between the 8:1 mux round-robin arbiter and its requesters.
// The arbiter side uses the slave modport; requesters (or a bench) use the master modport.
interface mux_rr_arbiter_if;
  // Handshake: req[i] is held high while requester i wants the mux. gnt is
  // one-hot and registered. Ownership lasts until the owner drops req[i] or
  // pulses done. done is only meaningful while busy=1.
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       s2;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       timeout;
  logic       dbg_state;
  logic [2:0] dbg_ptr;

  modport master (
    output req, done,
    input  gnt, s2, s1, s0, busy, timeout, dbg_state, dbg_ptr
  );

  modport slave (
    input  req, done,
    output gnt, s2, s1, s0, busy, timeout, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of an 8:1 mux, one grant at a time.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_rr_arbiter_if.slave    io_arb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_owner;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;
  logic [2:0] w_pick;
  logic       w_any_req;
  logic       w_rel_norm;
  logic       w_force;
  logic       w_release;

  assign w_any_req  = |io_arb.req;
  assign w_rel_norm = io_arb.done | ~io_arb.req[r_owner];
  assign w_release  = w_rel_norm | w_force;

  // Walk from the farthest offset back to ptr so the nearest set request wins.
  always_comb begin
    w_pick = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      if (io_arb.req[r_ptr + 3'(k)]) begin
        w_pick = r_ptr + 3'(k);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_next = GRANT;
      GRANT:   if (w_release) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Owner keeps its last value through IDLE; gnt alone marks it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 3'd0;
      r_ptr   <= 3'd0;
      r_gnt   <= 8'h00;
    end else if (r_state == IDLE) begin
      if (w_any_req) begin
        r_owner <= w_pick;
        r_gnt   <= 8'd1 << w_pick;
      end
    end else if (w_release) begin
      r_gnt <= 8'h00;
      r_ptr <= r_owner + 3'd1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_timeout;

  // A normal release on the same edge wins, so no timeout pulse is raised.
  assign w_force = (r_state == GRANT) && (r_cnt == 8'(HOLD_MAX - 1)) && !w_rel_norm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == IDLE) begin
        r_cnt <= 8'd0;
      end else if (!w_release && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign io_arb.timeout = r_timeout;
`else
  logic [7:0] w_unused_hold;

  assign w_force        = 1'b0;
  assign w_unused_hold  = 8'(HOLD_MAX);
  assign io_arb.timeout = 1'b0;
`endif

  assign io_arb.gnt       = r_gnt;
  assign io_arb.s2        = r_owner[2];
  assign io_arb.s1        = r_owner[1];
  assign io_arb.s0        = r_owner[0];
  assign io_arb.busy      = (r_state == GRANT);
  assign io_arb.dbg_state = r_state;
  assign io_arb.dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter; expected grants are hand-computed.
// Exercises the ARB_TIMEOUT_EN build with HOLD_MAX=4 when that macro is defined.
module tb_mux_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD = 4;
`else
  localparam int unsigned HOLD = 16;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_rr_arbiter_if arb ();

  mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_arb (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input string tag, input int idx);
    logic [7:0] g;
    g = 8'd1 << idx;
    check({tag, ".gnt"}, 32'(arb.gnt), 32'(g));
    check({tag, ".sel"}, 32'({arb.s2, arb.s1, arb.s0}), 32'(idx));
    check({tag, ".busy"}, 32'(arb.busy), 32'd1);
  endtask

  task automatic exp_idle(input string tag);
    check({tag, ".gnt"}, 32'(arb.gnt), 32'h0);
    check({tag, ".busy"}, 32'(arb.busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arb.req  = 8'h00;
    arb.done = 1'b0;
    rst_n    = 1'b0;

    // Reset state
    #3;
    exp_idle("rst");
    check("rst.sel", 32'({arb.s2, arb.s1, arb.s0}), 32'd0);
    check("rst.timeout", 32'(arb.timeout), 32'd0);
    check("rst.ptr", 32'(arb.dbg_ptr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_idle("post_rst");

    // Single requester 5
    arb.req = 8'h20;
    tick();
    exp_grant("single", 5);
    arb.done = 1'b1;
    tick();
    exp_idle("single_rel");
    check("single_rel.ptr", 32'(arb.dbg_ptr), 32'd6);
    arb.done = 1'b0;
    arb.req  = 8'h00;
    tick();
    exp_idle("single_after");

    // Round-robin with all requesting, pointer back to 0 first
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    arb.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_grant($sformatf("rr%0d", i), i % 8);
      tick();
      exp_grant($sformatf("rr%0d_hold", i), i % 8);
      arb.done = 1'b1;
      tick();
      exp_idle($sformatf("rr%0d_dead", i));
      arb.done = 1'b0;
    end
    check("rr_end.ptr", 32'(arb.dbg_ptr), 32'd1);

    // Pointer skip via wrap
    arb.req = 8'h40;
    tick();
    exp_grant("skip6", 6);
    arb.done = 1'b1;
    tick();
    exp_idle("skip6_rel");
    check("skip6_rel.ptr", 32'(arb.dbg_ptr), 32'd7);
    arb.done = 1'b0;
    arb.req  = 8'h05;
    tick();
    exp_grant("skip_wrap", 0);
    arb.done = 1'b1;
    tick();
    exp_idle("skip_wrap_rel");
    arb.done = 1'b0;
    tick();
    exp_grant("skip_next", 2);
    arb.req = 8'h00;
    tick();
    exp_idle("skip_next_rel");
    check("skip_next_rel.ptr", 32'(arb.dbg_ptr), 32'd3);

    // Owner 3 with other requests arriving, then drops its request
    arb.req = 8'h08;
    tick();
    exp_grant("own3", 3);
    arb.req = 8'h7F;
    tick();
    exp_grant("own3_others", 3);
    arb.req = 8'h77;
    tick();
    exp_idle("own3_drop");
    check("own3_drop.ptr", 32'(arb.dbg_ptr), 32'd4);
    arb.req  = 8'h00;
    arb.done = 1'b1;
    tick();
    exp_idle("idle_done");
    check("idle_done.ptr", 32'(arb.dbg_ptr), 32'd4);
    arb.done = 1'b0;

    // done and req drop together: one release
    arb.req = 8'h10;
    tick();
    exp_grant("both", 4);
    arb.req  = 8'h00;
    arb.done = 1'b1;
    tick();
    exp_idle("both_rel");
    check("both_rel.ptr", 32'(arb.dbg_ptr), 32'd5);
    arb.done = 1'b0;
    tick();
    exp_idle("both_after");

    // Hold with no release
    arb.req = 8'h01;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_grant($sformatf("to_hold%0d", c), 0);
      check($sformatf("to_hold%0d.timeout", c), 32'(arb.timeout), 32'd0);
    end
    tick();
    exp_idle("to_force");
    check("to_force.timeout", 32'(arb.timeout), 32'd1);
    check("to_force.ptr", 32'(arb.dbg_ptr), 32'd1);
    tick();
    exp_grant("to_regrant", 0);
    check("to_regrant.timeout", 32'(arb.timeout), 32'd0);
    tick();
    tick();
    tick();
    exp_grant("to_last", 0);
    arb.done = 1'b1;
    tick();
    exp_idle("to_prec");
    check("to_prec.timeout", 32'(arb.timeout), 32'd0);
    arb.done = 1'b0;
    arb.req  = 8'h00;
    tick();
`else
    for (int c = 0; c < 110; c++) begin
      tick();
      exp_grant($sformatf("hold%0d", c), 0);
      check($sformatf("hold%0d.timeout", c), 32'(arb.timeout), 32'd0);
    end
    arb.req = 8'h00;
    tick();
    exp_idle("hold_rel");
    tick();
`endif

    // Asynchronous reset in the middle of a grant
    arb.req = 8'h80;
    tick();
    exp_grant("mid", 7);
    #2;
    rst_n = 1'b0;
    #1;
    exp_idle("mid_rst");
    check("mid_rst.sel", 32'({arb.s2, arb.s1, arb.s0}), 32'd0);
    check("mid_rst.ptr", 32'(arb.dbg_ptr), 32'd0);
    arb.req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    exp_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
